// File: rtl/alu_cmp_pipe.sv
// Pipelined 6502-style compare/flag unit: CMP, signed compare, BIT and SBC over a WIDTH-bit
// datapath, with an elastic valid/ready pipeline of STAGES register slots.
module alu_cmp_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [7:0]       flags_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       flags_out,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    localparam logic [1:0] MODE_CMP  = 2'd0;
    localparam logic [1:0] MODE_SCMP = 2'd1;
    localparam logic [1:0] MODE_BIT  = 2'd2;
    localparam logic [1:0] MODE_SBC  = 2'd3;

    localparam int FLAG_N = 7;
    localparam int FLAG_V = 6;
    localparam int FLAG_Z = 1;
    localparam int FLAG_C = 0;

    logic             w_borrow_in;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_and;
    logic             w_ovf;
    logic [WIDTH-1:0] w_res;
    logic [7:0]       w_flags;

    // SBC consumes the inverted carry as a borrow; the extra top bit of the difference is the borrow out.
    assign w_borrow_in = (mode == MODE_SBC) && !flags_in[FLAG_C];
    assign w_diff      = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, w_borrow_in};
    assign w_and       = a & b;
    assign w_ovf       = (a[WIDTH-1] ^ b[WIDTH-1]) & (a[WIDTH-1] ^ w_diff[WIDTH-1]);

    always_comb begin
        w_res   = w_diff[WIDTH-1:0];
        w_flags = flags_in;
        case (mode)
            MODE_CMP: begin
                w_flags[FLAG_N] = w_diff[WIDTH-1];
                w_flags[FLAG_Z] = (w_diff[WIDTH-1:0] == '0);
                w_flags[FLAG_C] = !w_diff[WIDTH];
            end
            MODE_SCMP, MODE_SBC: begin
                w_flags[FLAG_N] = w_diff[WIDTH-1];
                w_flags[FLAG_V] = w_ovf;
                w_flags[FLAG_Z] = (w_diff[WIDTH-1:0] == '0);
                w_flags[FLAG_C] = !w_diff[WIDTH];
            end
            MODE_BIT: begin
                w_res           = w_and;
                w_flags[FLAG_N] = b[WIDTH-1];
                w_flags[FLAG_V] = b[WIDTH-2];
                w_flags[FLAG_Z] = (w_and == '0);
            end
            default: begin
                w_res   = w_diff[WIDTH-1:0];
                w_flags = flags_in;
            end
        endcase
    end

    logic [STAGES-1:0] w_valid;
    logic [STAGES-1:0] w_load;
    logic [WIDTH-1:0]  w_slot_res   [STAGES];
    logic [7:0]        w_slot_flags [STAGES];
    logic              w_chain;

    // A slot loads when it, or any slot downstream of it, is empty, or the consumer takes the output.
    always_comb begin
        w_load  = '0;
        w_chain = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            w_chain   = w_chain | !w_valid[k];
            w_load[k] = w_chain;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_slot
            logic             w_up_valid;
            logic [WIDTH-1:0] w_up_res;
            logic [7:0]       w_up_flags;
            logic             r_valid;
            logic [WIDTH-1:0] r_res;
            logic [7:0]       r_flags;

            if (gi == 0) begin : g_head
                assign w_up_valid = in_valid;
                assign w_up_res   = w_res;
                assign w_up_flags = w_flags;
            end else begin : g_body
                assign w_up_valid = w_valid[gi-1];
                assign w_up_res   = w_slot_res[gi-1];
                assign w_up_flags = w_slot_flags[gi-1];
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_valid <= 1'b0;
                    r_res   <= '0;
                    r_flags <= '0;
                end else if (w_load[gi]) begin
                    r_valid <= w_up_valid;
                    if (w_up_valid) begin
                        r_res   <= w_up_res;
                        r_flags <= w_up_flags;
                    end
                end
            end

            assign w_valid[gi]      = r_valid;
            assign w_slot_res[gi]   = r_res;
            assign w_slot_flags[gi] = r_flags;
        end
    endgenerate

    assign in_ready  = w_load[0];
    assign out_valid = w_valid[STAGES-1];
    assign result    = w_slot_res[STAGES-1];
    assign flags_out = w_slot_flags[STAGES-1];
    assign busy      = |w_valid;

endmodule

// File: tb/tb_alu_cmp_pipe.sv
// Directed bench for alu_cmp_pipe: 8-bit and 16-bit single-stage units plus a 3-stage unit
// exercised through stall, drain, latency and asynchronous reset.
module tb_alu_cmp_pipe;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // 8-bit, 1 stage
    logic       a_in_valid = 0, a_out_ready = 1;
    logic       a_in_ready, a_out_valid, a_busy;
    logic [1:0] a_mode = 0;
    logic [7:0] a_a = 0, a_b = 0, a_fin = 0, a_fout, a_res;

    alu_cmp_pipe #(.WIDTH(8), .STAGES(1)) u_a (
        .clk(clk), .reset_n(reset_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .mode(a_mode), .a(a_a), .b(a_b), .flags_in(a_fin), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .flags_out(a_fout), .result(a_res), .busy(a_busy));

    // 16-bit, 1 stage
    logic        w_in_valid = 0, w_out_ready = 1;
    logic        w_in_ready, w_out_valid, w_busy;
    logic [1:0]  w_mode = 0;
    logic [15:0] w_a = 0, w_b = 0, w_res;
    logic [7:0]  w_fin = 0, w_fout;

    alu_cmp_pipe #(.WIDTH(16), .STAGES(1)) u_w (
        .clk(clk), .reset_n(reset_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .mode(w_mode), .a(w_a), .b(w_b), .flags_in(w_fin), .out_valid(w_out_valid),
        .out_ready(w_out_ready), .flags_out(w_fout), .result(w_res), .busy(w_busy));

    // 8-bit, 3 stages
    logic       c_in_valid = 0, c_out_ready = 0;
    logic       c_in_ready, c_out_valid, c_busy;
    logic [1:0] c_mode = 0;
    logic [7:0] c_a = 0, c_b = 0, c_fin = 0, c_fout, c_res;

    alu_cmp_pipe #(.WIDTH(8), .STAGES(3)) u_c (
        .clk(clk), .reset_n(reset_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .mode(c_mode), .a(c_a), .b(c_b), .flags_in(c_fin), .out_valid(c_out_valid),
        .out_ready(c_out_ready), .flags_out(c_fout), .result(c_res), .busy(c_busy));

    task automatic op8(input string tag, input logic [1:0] m, input logic [7:0] av,
                       input logic [7:0] bv, input logic [7:0] fv,
                       input logic [7:0] exp_res, input logic [7:0] exp_flags);
        a_mode = m; a_a = av; a_b = bv; a_fin = fv; a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        check_eq({tag, "_valid"}, 32'(a_out_valid), 32'd1);
        check_eq({tag, "_res"}, 32'(a_res), 32'(exp_res));
        check_eq({tag, "_flags"}, 32'(a_fout), 32'(exp_flags));
    endtask

    task automatic op16(input string tag, input logic [1:0] m, input logic [15:0] av,
                        input logic [15:0] bv, input logic [7:0] fv,
                        input logic [15:0] exp_res, input logic [7:0] exp_flags);
        w_mode = m; w_a = av; w_b = bv; w_fin = fv; w_in_valid = 1'b1;
        tick();
        w_in_valid = 1'b0;
        check_eq({tag, "_valid"}, 32'(w_out_valid), 32'd1);
        check_eq({tag, "_res"}, 32'(w_res), 32'(exp_res));
        check_eq({tag, "_flags"}, 32'(w_fout), 32'(exp_flags));
    endtask

    initial begin
        int sent, got, first_cyc, last_cyc;
        logic acc;

        #1;
        check_eq("rst_a_valid", 32'(a_out_valid), 32'd0);
        check_eq("rst_c_busy", 32'(c_busy), 32'd0);
        check_eq("rst_c_flags", 32'(c_fout), 32'd0);
        check_eq("rst_c_res", 32'(c_res), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        #1;
        check_eq("rel_a_in_ready", 32'(a_in_ready), 32'd1);
        check_eq("rel_c_in_ready", 32'(c_in_ready), 32'd1);

        // single-stage 8-bit vectors
        op8("cmp_eq",   2'd0, 8'h01, 8'h01, 8'h00, 8'h00, 8'h03);
        op8("cmp_lt",   2'd0, 8'h01, 8'h02, 8'hC3, 8'hFF, 8'hC0);
        op8("scmp_ovf", 2'd1, 8'h80, 8'h01, 8'h00, 8'h7F, 8'h41);
        op8("bit_zero", 2'd2, 8'h0F, 8'hC0, 8'h00, 8'h00, 8'hC2);
        op8("sbc_wrap", 2'd3, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h02);
        op8("sbc_c1",   2'd3, 8'h05, 8'h03, 8'h01, 8'h02, 8'h01);
        op8("bit_cpass",2'd2, 8'hFF, 8'h3F, 8'h01, 8'h3F, 8'h01);
        op8("cmp_pass", 2'd0, 8'h10, 8'h20, 8'h3C, 8'hF0, 8'hBC);
        tick();
        check_eq("a_drained", 32'(a_out_valid), 32'd0);
        check_eq("a_busy_idle", 32'(a_busy), 32'd0);

        // 16-bit vectors
        op16("w_sbc_ovf",  2'd3, 16'h8000, 16'h0001, 8'h01, 16'h7FFF, 8'h41);
        op16("w_sbc_wrap", 2'd3, 16'h0000, 16'hFFFF, 8'h00, 16'h0000, 8'h02);
        op16("w_scmp",     2'd1, 16'h7FFF, 16'hFFFF, 8'h00, 16'h8000, 8'hC0);

        // 3-stage: fill while stalled
        c_mode = 2'd0; c_fin = 8'h00; c_out_ready = 1'b0;
        sent = 0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            c_in_valid = (sent < 8);
            c_a = 8'(sent * 17 + 3);
            c_b = 8'(sent);
            #1;
            acc = c_in_valid && c_in_ready;
            tick();
            if (acc) sent++;
        end
        check_eq("stall_accepted", 32'(sent), 32'd3);
        check_eq("stall_in_ready", 32'(c_in_ready), 32'd0);
        check_eq("stall_busy", 32'(c_busy), 32'd1);
        check_eq("stall_out_valid", 32'(c_out_valid), 32'd1);
        check_eq("stall_hold_res", 32'(c_res), 32'h03);
        check_eq("stall_hold_flags", 32'(c_fout), 32'h01);

        // release and drain in order
        c_out_ready = 1'b1;
        got = 0; first_cyc = -1; last_cyc = -1;
        for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
            c_in_valid = (sent < 8);
            c_a = 8'(sent * 17 + 3);
            c_b = 8'(sent);
            #1;
            acc = c_in_valid && c_in_ready;
            if (c_out_valid && c_out_ready) begin
                check_eq($sformatf("drain_res%0d", got), 32'(c_res), 32'(8'(got * 16 + 3)));
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                got++;
            end
            tick();
            if (acc) sent++;
        end
        c_in_valid = 1'b0;
        check_eq("drain_count", 32'(got), 32'd8);
        check_eq("drain_no_gap", 32'(last_cyc - first_cyc), 32'd7);
        tick();
        check_eq("drain_empty", 32'(c_busy), 32'd0);

        // latency of 3 from an empty pipe
        c_a = 8'h09; c_b = 8'h04; c_fin = 8'h3C; c_in_valid = 1'b1;
        tick();
        c_in_valid = 1'b0;
        check_eq("lat_edge1", 32'(c_out_valid), 32'd0);
        tick();
        check_eq("lat_edge2", 32'(c_out_valid), 32'd0);
        tick();
        check_eq("lat_edge3", 32'(c_out_valid), 32'd1);
        check_eq("lat_res", 32'(c_res), 32'h05);
        tick();

        // two ops in flight, stalled, then asynchronous reset
        c_out_ready = 1'b0;
        c_a = 8'h20; c_b = 8'h10; c_fin = 8'h3C; c_in_valid = 1'b1;
        tick();
        c_a = 8'h21;
        tick();
        c_in_valid = 1'b0;
        tick();
        check_eq("inflight_valid", 32'(c_out_valid), 32'd1);
        check_eq("inflight_flags", 32'(c_fout), 32'h3D);
        #2 reset_n = 1'b0;
        #1;
        check_eq("async_out_valid", 32'(c_out_valid), 32'd0);
        check_eq("async_busy", 32'(c_busy), 32'd0);
        check_eq("async_flags", 32'(c_fout), 32'h00);
        check_eq("async_res", 32'(c_res), 32'h00);
        #3 reset_n = 1'b1;
        tick();
        check_eq("post_rst_in_ready", 32'(c_in_ready), 32'd1);
        c_out_ready = 1'b1;
        c_a = 8'h05; c_b = 8'h07; c_fin = 8'h00; c_in_valid = 1'b1;
        tick();
        c_in_valid = 1'b0;
        repeat (2) tick();
        check_eq("post_rst_valid", 32'(c_out_valid), 32'd1);
        check_eq("post_rst_res", 32'(c_res), 32'hFE);
        check_eq("post_rst_flags", 32'(c_fout), 32'h80);
        tick();
        check_eq("post_rst_drained", 32'(c_busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_cmp_pipe.md
Name: alu_cmp_pipe

Overview:
- Parametrised, pipelined compare/flag unit for the cpu6502 ALU path.
- Computes 6502-style N/V/Z/C flag updates for CMP, signed compare, BIT and SBC over a WIDTH-bit datapath.
- Merges the updated flags into the incoming P register and returns the difference.
- Replaces the fixed 8-bit combinational compare.
- Uses a valid/ready handshake so the control unit or a wider-word coprocessor can stall it.

Parameters:
- WIDTH, 8, operand/result width; legal range 4..32.
- STAGES, 1, pipeline depth; legal range 1..3; equals the latency in cycles.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand set presented.
- in_ready  output  1  unit accepts operands this cycle.
- mode  input  2  0=CMP, 1=SCMP, 2=BIT, 3=SBC.
- a  input  WIDTH  accumulator/index operand.
- b  input  WIDTH  memory/immediate operand.
- flags_in  input  8  current P register (N V 1 B D I Z C, bit7..bit0).
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result this cycle.
- flags_out  output  8  updated P register.
- result  output  WIDTH  a-b (CMP/SCMP), a-b-!C (SBC), a&b (BIT).
- busy  output  1  any pipeline stage holds valid data.

Behaviour:
- Accept on in_valid&in_ready. Output transfer on out_valid&out_ready.
- Arithmetic at WIDTH+1 bits:
  - CMP/SCMP: d = {0,a} - {0,b}.
  - SBC: d = {0,a} - {0,b} - !flags_in[0].
  - C = !d[WIDTH] (no borrow). Z = (d[WIDTH-1:0]==0). N = d[WIDTH-1].
- V:
  - SCMP/SBC: V = (a[W-1]^b[W-1]) & (a[W-1]^d[W-1]).
  - CMP: V passes through from flags_in[6].
- BIT: Z = ((a&b)==0), N = b[W-1], V = b[W-2]; C passes through.
- Bits 5,4,3,2 always pass through from flags_in unchanged. Unmodified flags pass through per mode.
- Pipeline: STAGES register slots, each with its own valid bit.
  - Flag computation is complete in slot 0; later slots only carry data.
  - Elastic rule: slot k loads when it is empty or slot k+1 loads (last slot: when out_ready).
  - in_ready = !slot0_valid | slot0_advances. Combinational from out_ready through the chain; no bubble at full throughput.
- Latency: an operand accepted at edge t appears with out_valid=1 after edge t+STAGES-1. STAGES=1 means registered after one edge.
- Stall: out_valid&!out_ready holds result and flags_out stable; upstream slots fill, then in_ready=0.
- Simultaneous accept and output transfer in the same cycle is legal; no data loss or duplication.
- Order preserved; no reordering across modes.
- busy = OR of all slot valid bits.
- Reset (reset_n=0, async, at any time including mid-stall):
  - All valid bits 0.
  - out_valid=0, result=0, flags_out=8'h00, busy=0. in_ready=1 once released.
  - In-flight data is discarded.
- Wrap-around: SBC with a=0, b=max, C=0 gives result=0 and C=0. No saturation anywhere.
- mode latched with operands; a change while stalled has no effect on held data.

Test Plan:
- Reset then WIDTH=8, STAGES=1: CMP a=01 b=01 flags_in=00 -> one cycle later out_valid=1, flags_out=03, result=00.
- CMP a=01 b=02 flags_in=C3 -> flags_out=C0 (N=1, V kept, Z=0, C=0), result=FF.
- SCMP a=80 b=01 flags_in=00 -> result=7F, flags_out=41 (V=1, C=1); BIT a=0F b=C0 -> flags_out=C2.
- SBC chain: a=00 b=FF C=0 -> result=00, C=0, Z=1; WIDTH=16 SBC a=8000 b=0001 C=1 -> result=7FFF, V=1, C=1.
- STAGES=3, 8 back-to-back ops with out_ready=0 for 5 cycles: in_ready drops after 3 accepted; release -> all 8 results in order, one per cycle, latency 3.
- Assert reset_n low with 2 ops in flight -> out_valid, busy, flags_out clear immediately without a clock edge; next op after release completes normally.
